muldiv_unit: RTL and testbench

Iterative 16-bit multiply/divide unit in the EX stage of the 16-bit pipeline. It accepts one operation at a time, computes it over several cycles, and reports progress on a 2-bit `alu_status` bus. The hazard logic stalls IF/ID and ID/EX whenever `alu_status > 2'b01`. On completion it presents a result and destination-register tag to the writeback path.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   // Controller state; doubles as the alu_status encoding seen by hazard logic.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DONE = 2'b01,
      ST_RUN  = 2'b10,
      ST_LOAD = 2'b11
   } state_e;

   // Operation select.
   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   // Quotient returned for a zero divisor.
   localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

   // True for the two divide-class operations.
   function automatic logic is_div_op(input op_e op_v);
      return (op_v == OP_DIVU) || (op_v == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath.
// Multiply: {hi,lo} holds {partial product, remaining multiplier}; add the
//   multiplicand into hi when lo[0] is set, then shift the pair right.
// Divide: {hi,lo} holds {partial remainder, dividend/quotient}; shift the
//   pair left, trial-subtract the divisor and keep the result on no borrow.
module muldiv_step #(
   parameter int XLEN = 16
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum_s;
   logic [XLEN:0] shl_s;
   logic [XLEN:0] diff_s;

   // Compute both candidate steps and select by operation class.
   always_comb begin
      sum_s  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
      shl_s  = {hi_i, lo_i[XLEN-1]};
      diff_s = shl_s - {1'b0, opnd_i};
      hi_o   = hi_i;
      lo_o   = lo_i;
      if (is_div_i) begin
         // Partial remainder is always below the divisor, so bit XLEN of the
         // difference is set only when the trial subtraction borrowed.
         if (!diff_s[XLEN]) begin
            hi_o = diff_s[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            hi_o = shl_s[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_o = sum_s[XLEN:1];
         lo_o = {sum_s[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit multiply/divide unit with status-driven stall interface.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 16,
   parameter int ITER = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [3:0]      rd_in,
   input  logic            flush,
   output logic [1:0]      alu_status,
   output logic [XLEN-1:0] result,
   output logic [3:0]      rd_out,
   output logic            wb_en
);

   localparam int CW = $clog2(ITER);

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      rd_q, rd_d;
   logic            wb_q, wb_d;

   logic            is_div_s;
   logic            div0_s;
   logic            last_s;
   logic            accept_s;
   logic [XLEN-1:0] opnd_s;
   logic [XLEN-1:0] step_hi_s;
   logic [XLEN-1:0] step_lo_s;

   assign is_div_s = is_div_op(op_q);
   assign opnd_s   = is_div_s ? b_q : a_q;
   assign div0_s   = is_div_s && (b_q == {XLEN{1'b0}});
   assign last_s   = (cnt_q == CW'(ITER - 1));
   // New work is taken only when the unit is free; flush always wins.
   assign accept_s = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (is_div_s),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .opnd_i   (opnd_s),
      .hi_o     (step_hi_s),
      .lo_o     (step_lo_s)
   );

   // Next-state logic for the IDLE/LOAD/RUN/DONE controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
            else       state_d = ST_IDLE;
         end
         ST_LOAD: begin
            if (div0_s) state_d = ST_DONE;
            else        state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last_s) state_d = ST_DONE;
            else        state_d = ST_RUN;
         end
         ST_DONE: begin
            if (start) state_d = ST_LOAD;
            else       state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
      else       state_d = state_d;
   end

   // Operand capture, iteration datapath and registered output staging.
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rd_d     = rd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      wb_d     = (state_d == ST_DONE);

      if (accept_s) begin
         op_d = op_e'(op);
         a_d  = src_a;
         b_d  = src_b;
         rd_d = rd_in;
      end else if (flush) begin
         rd_d = 4'd0;
      end else begin
         rd_d = rd_q;
      end

      if (state_q == ST_LOAD) begin
         hi_d  = {XLEN{1'b0}};
         lo_d  = is_div_s ? a_q : b_q;
         cnt_d = {CW{1'b0}};
      end else if (state_q == ST_RUN) begin
         hi_d  = step_hi_s;
         lo_d  = step_lo_s;
         cnt_d = cnt_q + CW'(1);
      end else begin
         hi_d  = hi_q;
         lo_d  = lo_q;
         cnt_d = cnt_q;
      end

      // The final RUN step is folded straight into the result register.
      if (state_d == ST_DONE) begin
         if (state_q == ST_LOAD) begin
            result_d = (op_q == OP_DIVU) ? DIV0_QUOT : a_q;
         end else begin
            case (op_q)
               OP_MUL:   result_d = step_lo_s;
               OP_MULHU: result_d = step_hi_s;
               OP_DIVU:  result_d = step_lo_s;
               OP_REMU:  result_d = step_hi_s;
               default:  result_d = result_q;
            endcase
         end
      end else begin
         result_d = result_q;
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         a_q      <= {XLEN{1'b0}};
         b_q      <= {XLEN{1'b0}};
         hi_q     <= {XLEN{1'b0}};
         lo_q     <= {XLEN{1'b0}};
         cnt_q    <= {CW{1'b0}};
         rd_q     <= 4'd0;
         result_q <= {XLEN{1'b0}};
         wb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         wb_q     <= wb_d;
      end
   end

   assign alu_status = state_q;
   assign result     = result_q;
   assign rd_out     = rd_q;
   assign wb_en      = wb_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an expectation queue filled from plain
// arithmetic is checked every cycle, plus literal spot checks.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] src_a;
   logic [15:0] src_b;
   logic [3:0]  rd_in;
   logic        flush;
   logic [1:0]  alu_status;
   logic [15:0] result;
   logic [3:0]  rd_out;
   logic        wb_en;

   muldiv_unit #(.XLEN(16), .ITER(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op         (op),
      .src_a      (src_a),
      .src_b      (src_b),
      .rd_in      (rd_in),
      .flush      (flush),
      .alu_status (alu_status),
      .result     (result),
      .rd_out     (rd_out),
      .wb_en      (wb_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  st;
      logic [15:0] res;
      logic [3:0]  rd;
      bit          chk_rd;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] last_res;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference result straight from the arithmetic definition.
   function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = {16'd0, a} * {16'd0, b};
      case (o)
         2'd0:    return p[15:0];
         2'd1:    return p[31:16];
         2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
         default: return (b == 16'd0) ? a : a % b;
      endcase
   endfunction

   // Per-cycle compare against the expectation queue (IDLE when empty).
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else begin
            e.st = 2'b00; e.res = 16'd0; e.rd = 4'd0; e.chk_rd = 1'b0;
         end
         if (e.st == 2'b01) last_res = e.res;
         else               e.res = last_res;
         chk("status", {14'd0, alu_status}, {14'd0, e.st});
         chk("wb_en", {15'd0, wb_en}, {15'd0, (e.st == 2'b01)});
         chk("result", result, e.res);
         if (e.chk_rd) chk("rd_out", {12'd0, rd_out}, {12'd0, e.rd});
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one operation (call just after a rising edge) and queue its timeline.
   task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
      op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_q.push_back('{2'b11, 16'd0, 4'd0, 1'b0});
      if (!(o[1] && (b == 16'd0))) begin
         for (int i = 0; i < 16; i++) exp_q.push_back('{2'b10, 16'd0, 4'd0, 1'b0});
      end
      exp_q.push_back('{2'b01, model(o, a, b), rd, 1'b1});
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() > 0) && (k < 60)) begin
         wait_cycles(1);
         k++;
      end
      if (exp_q.size() > 0) begin
         n_vec++; n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
         exp_q.delete();
      end
      wait_cycles(1);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      wait_cycles(1);
      flush = 1'b0;
      exp_q.delete();
      exp_q.push_back('{2'b00, 16'd0, 4'd0, 1'b1});
      chk("flush_status", {14'd0, alu_status}, 16'h0000);
      chk("flush_wb", {15'd0, wb_en}, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0;
      src_a = 16'd0; src_b = 16'd0; rd_in = 4'd0; last_res = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_status", {14'd0, alu_status}, 16'h0000);
      chk("reset_result", result, 16'h0000);
      chk("reset_wb", {15'd0, wb_en}, 16'h0000);
      rst_n = 1'b1;
      wait_cycles(2);

      // MUL 7*6 with full status sequence and one-cycle DONE
      issue(2'd0, 16'd7, 16'd6, 4'd3);
      wait_cycles(17);
      chk("mul_done_status", {14'd0, alu_status}, 16'h0001);
      chk("mul_result", result, 16'd42);
      chk("mul_rd", {12'd0, rd_out}, 16'd3);
      chk("mul_wb", {15'd0, wb_en}, 16'h0001);
      wait_cycles(1);
      chk("mul_after_status", {14'd0, alu_status}, 16'h0000);
      drain();

      // FFFF*FFFF low and high halves, latency check
      issue(2'd0, 16'hFFFF, 16'hFFFF, 4'd1);
      wait_cycles(16);
      chk("mul_lat_run", {14'd0, alu_status}, 16'h0002);
      wait_cycles(1);
      chk("mul_ffff", result, 16'h0001);
      drain();
      issue(2'd1, 16'hFFFF, 16'hFFFF, 4'd2);
      wait_cycles(17);
      chk("mulhu_status", {14'd0, alu_status}, 16'h0001);
      chk("mulhu_ffff", result, 16'hFFFE);
      drain();

      // DIVU / REMU 100/7
      issue(2'd2, 16'd100, 16'd7, 4'd4);
      wait_cycles(17);
      chk("divu_100_7", result, 16'd14);
      drain();
      issue(2'd3, 16'd100, 16'd7, 4'd5);
      wait_cycles(17);
      chk("remu_100_7", result, 16'd2);
      drain();

      // Divide by zero: LOAD then DONE
      issue(2'd2, 16'h1234, 16'd0, 4'd6);
      wait_cycles(1);
      chk("div0_status", {14'd0, alu_status}, 16'h0001);
      chk("div0_quot", result, 16'hFFFF);
      drain();
      issue(2'd3, 16'h1234, 16'd0, 4'd7);
      wait_cycles(1);
      chk("rem0_result", result, 16'h1234);
      drain();

      // start pulsed on RUN cycle 5 is ignored
      issue(2'd0, 16'd300, 16'd200, 4'd9);
      wait_cycles(5);
      op = 2'd2; src_a = 16'd55; src_b = 16'd3; rd_in = 4'd1; start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      wait_cycles(11);
      chk("ign_status", {14'd0, alu_status}, 16'h0001);
      chk("ign_result", result, 16'hEA60);
      chk("ign_rd", {12'd0, rd_out}, 16'd9);
      drain();

      // Back-to-back: start held in DONE goes straight to LOAD
      issue(2'd3, 16'd1000, 16'd33, 4'd2);
      wait_cycles(17);
      chk("b2b_first", result, 16'd10);
      issue(2'd1, 16'hABCD, 16'h1234, 4'd7);
      chk("b2b_load", {14'd0, alu_status}, 16'h0003);
      drain();

      // flush on RUN cycle 10
      issue(2'd2, 16'd5000, 16'd7, 4'd6);
      wait_cycles(10);
      do_flush();
      wait_cycles(3);

      // flush coincident with final RUN cycle: no DONE
      issue(2'd0, 16'd99, 16'd99, 4'd11);
      wait_cycles(16);
      do_flush();
      wait_cycles(3);

      // Asynchronous reset mid-RUN
      issue(2'd0, 16'd123, 16'd45, 4'd8);
      wait_cycles(8);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_status", {14'd0, alu_status}, 16'h0000);
      chk("arst_result", result, 16'h0000);
      chk("arst_rd", {12'd0, rd_out}, 16'h0000);
      chk("arst_wb", {15'd0, wb_en}, 16'h0000);
      exp_q.delete();
      last_res = 16'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cycles(2);

      // Recovery after reset
      issue(2'd0, 16'd7, 16'd6, 4'd3);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
